// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage in front of a dual-port, 16-bit, byte-addressed
// memory. Drives port A with the fetch PC and captures the big-endian word
// {mem[pc], mem[pc+1]} together with its PC into a small prefetch FIFO. The
// FIFO head is offered to the decoder.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   mem_addr  [15:0]   registered fetch PC driven to memory port A
//   mem_req            fetch request this cycle (combinational)
//   mem_gnt            port A granted to the fetch path this cycle
//   mem_rdata [15:0]   port A read data, combinational from mem_addr
//   out_valid          head entry present
//   out_ready          decoder accepts the head entry
//   out_instr [15:0]   head instruction word (zero when empty)
//   out_pc    [15:0]   byte address of the head word (zero when empty)
//   redirect_valid     branch/jump redirect: flush and restart at redirect_pc
//   redirect_pc [15:0] redirect target, any byte address (odd allowed)
//   halt               stop fetching; the FIFO keeps draining
//   halted             unit is in the HALTED state
//   count   [CW-1:0]   FIFO occupancy
//
// Handshakes (valid/ready): a transfer happens at a rising edge where both
// sides are high in the cycle before it. mem_req/mem_gnt pushes one word;
// out_valid/out_ready pops the head. Neither side may make its valid depend
// on its own ready. A redirect in the same cycle kills both transfers: the
// pushed word and the popped head are discarded, and the decoder must treat
// that handshake as never having happened.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic [15:0]   mem_addr,
  output logic          mem_req,
  input  logic          mem_gnt,
  input  logic [15:0]   mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_instr,
  output logic [15:0]   out_pc,
  input  logic          redirect_valid,
  input  logic [15:0]   redirect_pc,
  input  logic          halt,
  output logic          halted,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   instr_buf [DEPTH];
  logic [15:0]   pc_buf    [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;

  assign mem_addr = fetch_pc;
  assign halted   = (state == HALTED);

  // Requests are suppressed during a redirect so the word at the old PC is
  // never captured, and during reset so the memory sees no stray request.
  assign mem_req = !rst && (state == FETCH) && (count < CW'(DEPTH)) && !redirect_valid;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_buf[rd_ptr] : 16'h0000;
  assign out_pc    = out_valid ? pc_buf[rd_ptr]    : 16'h0000;

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;
    // mem_req already excludes the full case, so a pop in the same cycle
    // cannot open a slot for a push: there is no full pass-through.
    push       = mem_req && mem_gnt;
    pop        = out_valid && out_ready && !redirect_valid;
    count_next = count + CW'(push) - CW'(pop);
  end

  // Control path: PC, pointers, occupancy and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= FETCH;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= FETCH;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 16'd2;  // wraps 16'hFFFE -> 16'h0000
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      // HALTED is sticky until redirect or reset; a grant in the halt
      // cycle itself is still captured above.
      if (halt || state == HALTED) begin
        state <= HALTED;
      end else if (count_next == CW'(DEPTH)) begin
        state <= FULL;
      end else begin
        state <= FETCH;
      end
    end
  end

  // Data path: entries need no reset because an empty FIFO reads as zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_buf[wr_ptr] <= mem_rdata;
      pc_buf[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A byte-array memory answers port A. A queue
// model holds the {pc, instr} entries the FIFO must contain; one compare
// process checks every DUT output against it at each falling edge, and the
// directed sequence adds hand-computed literal checks.
// Memory contents: mem[i] = i[7:0] + 8'h11, except bytes 0..3 = 12 34 56 78.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          CW       = 3;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic          clk;
  logic          rst;
  logic [15:0]   mem_addr;
  logic          mem_req;
  logic          mem_gnt;
  logic [15:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc;
  logic          redirect_valid;
  logic [15:0]   redirect_pc;
  logic          halt;
  logic          halted;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [65536];
  logic [15:0] addr_p1;

  // Model state: queue of {pc, instr}, fetch PC, halted flag.
  logic [31:0] exp_q[$];
  logic [15:0] m_pc;
  logic        m_halted;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .count          (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- memory ----------------
  assign addr_p1   = mem_addr + 16'd1;
  assign mem_rdata = {mem[mem_addr], mem[addr_p1]};

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] b;
    b = a + 16'd1;
    return {mem[a], mem[b]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: what the FIFO holds after each edge, from the rules alone.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc     = redirect_pc;
      m_halted = 1'b0;
    end else begin
      bit can_req;
      bit do_pop;
      can_req = !m_halted && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() != 0) && out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (can_req && mem_gnt) begin
        exp_q.push_back({m_pc, word_at(m_pc)});
        m_pc = m_pc + 16'd2;
      end
      if (halt) m_halted = 1'b1;
    end
  end

  // Compare every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      logic        e_req;
      logic [31:0] head;
      e_req = !m_halted && (exp_q.size() < DEPTH) && !redirect_valid;
      head  = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      chk("mem_addr",  32'(mem_addr),  32'(m_pc));
      chk("mem_req",   32'(mem_req),   32'(e_req));
      chk("count",     32'(count),     32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("out_pc",    32'(out_pc),    32'(head[31:16]));
      chk("out_instr", 32'(out_instr), 32'(head[15:0]));
      chk("halted",    32'(halted),    32'(m_halted));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) + 8'h11;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

    rst = 1'b1; mem_gnt = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;

    // Reset values.
    #4;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'h0);
    chk("rst_pc", 32'(out_pc), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    cyc(); cyc();
    rst = 1'b0; mem_gnt = 1'b1; out_ready = 1'b1;

    // Streaming: one word per cycle, count steady at 1.
    cyc(); #4;
    chk("t1_pc0", 32'(out_pc), 32'h0000);
    chk("t1_in0", 32'(out_instr), 32'h1234);
    chk("t1_cnt0", 32'(count), 32'd1);
    cyc(); #4;
    chk("t1_pc1", 32'(out_pc), 32'h0002);
    chk("t1_in1", 32'(out_instr), 32'h5678);
    chk("t1_cnt1", 32'(count), 32'd1);

    // Fill to FULL from pc 0 with the decoder stalled.
    cyc();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    #4 chk("t2_req_redir", 32'(mem_req), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #4;
    chk("t2_cnt_flush", 32'(count), 32'd0);
    repeat (6) cyc();
    #4;
    chk("t2_cnt_full", 32'(count), 32'd4);
    chk("t2_req_full", 32'(mem_req), 32'd0);
    chk("t2_addr_full", 32'(mem_addr), 32'h0008);
    chk("t2_head", 32'(out_pc), 32'h0000);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #4;
      chk("t2_drain_pc", 32'(out_pc), 32'(2 + 2 * k));
    end
    chk("t2_resume_in", 32'(out_instr), 32'h191A);
    chk("t2_cnt3", 32'(count), 32'd3);

    // Redirect to an odd address with entries pending.
    redirect_to(16'h0101);
    #4;
    chk("t3_cnt", 32'(count), 32'd0);
    chk("t3_addr", 32'(mem_addr), 32'h0101);
    cyc(); #4;
    chk("t3_pc", 32'(out_pc), 32'h0101);
    chk("t3_in", 32'(out_instr), 32'h1213);

    // Wrap at the top of the address space.
    redirect_to(16'hFFFE);
    cyc(); #4;
    chk("t4_pc_fffe", 32'(out_pc), 32'hFFFE);
    chk("t4_in_fffe", 32'(out_instr), 32'h0F10);
    cyc(); #4;
    chk("t4_pc_0000", 32'(out_pc), 32'h0000);
    chk("t4_in_0000", 32'(out_instr), 32'h1234);
    redirect_to(16'hFFFF);
    cyc(); #4;
    chk("t4_pc_ffff", 32'(out_pc), 32'hFFFF);
    chk("t4_in_ffff", 32'(out_instr), 32'h1012);
    cyc(); #4;
    chk("t4_pc_0001", 32'(out_pc), 32'h0001);
    chk("t4_in_0001", 32'(out_instr), 32'h3456);

    // Grant toggling: only granted cycles push and advance the PC.
    out_ready = 1'b0;
    redirect_to(16'h0200);
    mem_gnt = 1'b1; cyc();
    mem_gnt = 1'b0; cyc();
    mem_gnt = 1'b1; cyc();
    mem_gnt = 1'b0; cyc();
    #4;
    chk("t5_cnt", 32'(count), 32'd2);
    chk("t5_addr", 32'(mem_addr), 32'h0204);

    // Halt with a grant in the same cycle: that word is still captured.
    halt = 1'b1; mem_gnt = 1'b1;
    cyc();
    halt = 1'b0;
    #4;
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_req_halt", 32'(mem_req), 32'd0);
    chk("t5_cnt_halt", 32'(count), 32'd3);
    out_ready = 1'b1;
    repeat (3) cyc();
    #4;
    chk("t5_drained", 32'(count), 32'd0);
    chk("t5_still_halted", 32'(halted), 32'd1);
    redirect_to(16'h0040);
    #4;
    chk("t5_unhalt", 32'(halted), 32'd0);
    chk("t5_addr40", 32'(mem_addr), 32'h0040);
    chk("t5_req40", 32'(mem_req), 32'd1);

    // Asynchronous reset mid-burst.
    out_ready = 1'b0;
    cyc(); cyc();
    #3 chk("t6_cnt_pre", 32'(count), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("t6_cnt", 32'(count), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_pc", 32'(out_pc), 32'h0);
    chk("t6_instr", 32'(out_instr), 32'h0);
    chk("t6_addr", 32'(mem_addr), 32'h0);
    chk("t6_req", 32'(mem_req), 32'd0);
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
